// File: rtl/reg_wport_arbiter_if.sv
// reg_wport_arbiter_if: request, queue-handshake and register-file write signals of the write-port arbiter
interface reg_wport_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0]     wb_reg_wdata;
   logic                  wb_reg_wea;
   logic [ADDR_W-1:0]     wb_reg_waddr;
   logic                  mc_valid;
   logic                  mc_ready;
   logic [ADDR_W-1:0]     mc_waddr;
   logic [DATA_W-1:0]     mc_wdata;
   logic                  dbg_valid;
   logic                  dbg_ready;
   logic [ADDR_W-1:0]     dbg_waddr;
   logic [DATA_W-1:0]     dbg_wdata;
   logic                  rf_wea;
   logic [ADDR_W-1:0]     rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic                  arb_stall;
   logic [2**ADDR_W-1:0]  pend_mask;
   modport master (
      output wb_reg_wdata, wb_reg_wea, wb_reg_waddr,
      output mc_valid, mc_waddr, mc_wdata,
      output dbg_valid, dbg_waddr, dbg_wdata,
      input  mc_ready, dbg_ready,
      input  rf_wea, rf_waddr, rf_wdata, arb_stall, pend_mask
   );
   modport slave (
      input  wb_reg_wdata, wb_reg_wea, wb_reg_waddr,
      input  mc_valid, mc_waddr, mc_wdata,
      input  dbg_valid, dbg_waddr, dbg_wdata,
      output mc_ready, dbg_ready,
      output rf_wea, rf_waddr, rf_wdata, arb_stall, pend_mask
   );
endinterface

// File: rtl/reg_wport_arbiter.sv
// reg_wport_arbiter: shares the register-file write port between write-back, queued multi-cycle results and debug
// Define REG_WPORT_DBG_EN to arbitrate the debug port; otherwise dbg_* is ignored and dbg_ready stays 0.
module reg_wport_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 3,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input logic              clk,
   input logic              rst_n,
   reg_wport_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ST_W  = $clog2(STARVE_MAX + 1);
   localparam int NREG  = 2**ADDR_W;

   logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] q_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ST_W-1:0]   starve_cnt;
   logic              rf_wea;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [NREG-1:0]   pend;
   logic              empty, full, stall, push;
   logic              head_grant, wb_grant, dbg_grant, g_wea;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;

   assign empty = count == '0;
   assign full  = count == CNT_W'(FIFO_DEPTH);
   assign stall = starve_cnt == ST_W'(STARVE_MAX);
   assign push  = bus.mc_valid & ~full;

   // A starving head pre-empts write-back; the frozen pipeline replays its write later.
   assign head_grant = ~empty & (stall | ~bus.wb_reg_wea);
   assign wb_grant   = bus.wb_reg_wea & ~(stall & ~empty);
   assign g_wea      = head_grant | wb_grant | dbg_grant;

`ifdef REG_WPORT_DBG_EN
   assign dbg_grant     = bus.dbg_valid & ~bus.wb_reg_wea & empty;
   assign bus.dbg_ready = dbg_grant & rst_n;
   // Select the granted requester's write.
   always_comb begin
      g_addr = head_grant ? q_addr[rd_ptr] : wb_grant ? bus.wb_reg_waddr : bus.dbg_waddr;
      g_data = head_grant ? q_data[rd_ptr] : wb_grant ? bus.wb_reg_wdata : bus.dbg_wdata;
   end
`else
   logic unused_dbg;
   assign unused_dbg    = ^{bus.dbg_valid, bus.dbg_waddr, bus.dbg_wdata};
   assign dbg_grant     = 1'b0;
   assign bus.dbg_ready = 1'b0;
   // Select the granted requester's write.
   always_comb begin
      g_addr = head_grant ? q_addr[rd_ptr] : bus.wb_reg_waddr;
      g_data = head_grant ? q_data[rd_ptr] : bus.wb_reg_wdata;
   end
`endif

   // Mark every register targeted by an occupied queue slot, walking from the head.
   always_comb begin
      pend = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (CNT_W'(i) < count) pend[q_addr[rd_ptr + PTR_W'(i)]] = 1'b1;
   end

   // Queue storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr] <= bus.mc_waddr;
         q_data[wr_ptr] <= bus.mc_wdata;
      end
   end

   // Queue pointers, occupancy, starvation counter and the registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rf_wea     <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (head_grant) rd_ptr <= rd_ptr + PTR_W'(1);
         count      <= count + CNT_W'(push) - CNT_W'(head_grant);
         starve_cnt <= (empty | head_grant) ? '0 : stall ? starve_cnt : starve_cnt + ST_W'(1);
         rf_wea     <= g_wea;
         if (g_wea) begin
            rf_waddr <= g_addr;
            rf_wdata <= g_data;
         end
      end
   end

   assign bus.mc_ready  = ~full;
   assign bus.arb_stall = stall;
   assign bus.pend_mask = pend;
   assign bus.rf_wea    = rf_wea;
   assign bus.rf_waddr  = rf_waddr;
   assign bus.rf_wdata  = rf_wdata;
endmodule

// File: tb/tb_reg_wport_arbiter.sv
// tb_reg_wport_arbiter: vector table plus corner sequences, with a write-order scoreboard on rf_*
module tb_reg_wport_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef REG_WPORT_DBG_EN
   localparam logic DBG = 1'b1;
`else
   localparam logic DBG = 1'b0;
`endif

   reg_wport_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus();
   reg_wport_arbiter #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic        wea;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        exp_wea;
      logic [2:0]  exp_addr;
      logic [15:0] exp_data;
   } vec_t;
   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
   } wr_t;

   vec_t tbl[5];
   wr_t  sb[$];
   int   vecs = 0;
   int   errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [2:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Every register-file write must match the oldest expected write.
   always @(posedge clk) begin
      wr_t e;
      #2;
      if (rst_n && bus.rf_wea === 1'b1) begin
         if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_write: got %0h:%0h expected none", bus.rf_waddr, bus.rf_wdata);
         end else begin
            e = sb.pop_front();
            chk("sb_waddr", 32'(bus.rf_waddr), 32'(e.addr));
            chk("sb_wdata", 32'(bus.rf_wdata), 32'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b1, 3'd3, 16'hBEEF};
      tbl[1] = '{1'b0, 3'd6, 16'h5555, 1'b0, 3'd3, 16'hBEEF};
      tbl[2] = '{1'b1, 3'd0, 16'h0001, 1'b1, 3'd0, 16'h0001};
      tbl[3] = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 16'hFFFF};
      tbl[4] = '{1'b0, 3'd2, 16'hAAAA, 1'b0, 3'd7, 16'hFFFF};
      bus.wb_reg_wea = 0; bus.wb_reg_waddr = 0; bus.wb_reg_wdata = 0;
      bus.mc_valid = 0; bus.mc_waddr = 0; bus.mc_wdata = 0;
      bus.dbg_valid = 0; bus.dbg_waddr = 0; bus.dbg_wdata = 0;
      repeat (2) cyc();
      chk("rst_rf_wea", 32'(bus.rf_wea), 0);
      chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
      chk("rst_rf_wdata", 32'(bus.rf_wdata), 0);
      chk("rst_mc_ready", 32'(bus.mc_ready), 1);
      chk("rst_pend_mask", 32'(bus.pend_mask), 0);
      chk("rst_arb_stall", 32'(bus.arb_stall), 0);
      chk("rst_dbg_ready", 32'(bus.dbg_ready), 0);
      @(negedge clk) rst_n = 1'b1;
      cyc();
      // write-back only vectors
      foreach (tbl[i]) begin
         bus.wb_reg_wea = tbl[i].wea;
         bus.wb_reg_waddr = tbl[i].addr;
         bus.wb_reg_wdata = tbl[i].data;
         if (tbl[i].wea) expect_wr(tbl[i].addr, tbl[i].data);
         cyc();
         chk("tbl_rf_wea", 32'(bus.rf_wea), 32'(tbl[i].exp_wea));
         chk("tbl_rf_waddr", 32'(bus.rf_waddr), 32'(tbl[i].exp_addr));
         chk("tbl_rf_wdata", 32'(bus.rf_wdata), 32'(tbl[i].exp_data));
      end
      bus.wb_reg_wea = 0;
      cyc();
      // single mc result with idle write-back
      bus.mc_valid = 1; bus.mc_waddr = 5; bus.mc_wdata = 16'h1234;
      expect_wr(5, 16'h1234);
      cyc();
      bus.mc_valid = 0;
      chk("mc_pend_mask", 32'(bus.pend_mask), 32'h20);
      chk("mc_rf_wea_idle", 32'(bus.rf_wea), 0);
      cyc();
      chk("mc_rf_wea", 32'(bus.rf_wea), 1);
      chk("mc_rf_waddr", 32'(bus.rf_waddr), 5);
      chk("mc_pend_clear", 32'(bus.pend_mask), 0);
      cyc();
      // starvation: continuous write-back forces arb_stall after 4 cycles
      bus.wb_reg_wea = 1; bus.wb_reg_waddr = 1; bus.wb_reg_wdata = 16'h1000;
      bus.mc_valid = 1; bus.mc_waddr = 2; bus.mc_wdata = 16'h00AA;
      expect_wr(1, 16'h1000);
      cyc();
      bus.mc_valid = 0;
      chk("st_pend_mask", 32'(bus.pend_mask), 32'h04);
      chk("st_stall0", 32'(bus.arb_stall), 0);
      for (int k = 1; k <= 4; k++) begin
         bus.wb_reg_wdata = 16'h1000 + 16'(k);
         expect_wr(1, bus.wb_reg_wdata);
         cyc();
         chk("st_stall", 32'(bus.arb_stall), (k == 4) ? 1 : 0);
      end
      bus.wb_reg_wdata = 16'h1005;
      expect_wr(2, 16'h00AA);
      cyc();
      chk("st_head_addr", 32'(bus.rf_waddr), 2);
      chk("st_stall_drop", 32'(bus.arb_stall), 0);
      expect_wr(1, 16'h1005);
      cyc();
      bus.wb_reg_wea = 0;
      chk("st_wb_resume", 32'(bus.rf_wdata), 32'h1005);
      cyc();
      // full queue: third result held until first pop, order preserved
      bus.wb_reg_wea = 1; bus.wb_reg_waddr = 4;
      bus.mc_valid = 1; bus.mc_waddr = 6;
      for (int k = 0; k <= 4; k++) begin
         bus.wb_reg_wdata = 16'h2000 + 16'(k);
         expect_wr(4, bus.wb_reg_wdata);
         if (k <= 2) bus.mc_wdata = 16'h0A01 + 16'(k);
         #1;
         chk("full_mc_ready", 32'(bus.mc_ready), (k < 2) ? 1 : 0);
         if (k == 2) chk("full_pend_mask", 32'(bus.pend_mask), 32'h40);
         cyc();
      end
      chk("full_stall", 32'(bus.arb_stall), 1);
      chk("full_ready_pop", 32'(bus.mc_ready), 0);
      bus.wb_reg_wdata = 16'h2005;
      expect_wr(6, 16'h0A01);
      cyc();
      chk("full_ready_reopen", 32'(bus.mc_ready), 1);
      chk("full_stall_drop", 32'(bus.arb_stall), 0);
      expect_wr(4, 16'h2005);
      cyc();
      bus.mc_valid = 0; bus.wb_reg_wea = 0;
      chk("full_again", 32'(bus.mc_ready), 0);
      expect_wr(6, 16'h0A02);
      cyc();
      expect_wr(6, 16'h0A03);
      cyc();
      chk("full_drained_ready", 32'(bus.mc_ready), 1);
      chk("full_drained_pend", 32'(bus.pend_mask), 0);
      // debug waits for empty queue and idle write-back
      bus.wb_reg_wea = 1; bus.wb_reg_waddr = 0; bus.wb_reg_wdata = 16'h3000;
      bus.mc_valid = 1; bus.mc_waddr = 1; bus.mc_wdata = 16'h0B0B;
      bus.dbg_valid = 1; bus.dbg_waddr = 7; bus.dbg_wdata = 16'h0F0F;
      expect_wr(0, 16'h3000);
      #1;
      chk("dbg_ready_wb", 32'(bus.dbg_ready), 0);
      cyc();
      bus.mc_valid = 0; bus.wb_reg_wea = 0;
      expect_wr(1, 16'h0B0B);
      #1;
      chk("dbg_ready_queue", 32'(bus.dbg_ready), 0);
      cyc();
      if (DBG) expect_wr(7, 16'h0F0F);
      chk("dbg_ready_grant", 32'(bus.dbg_ready), 32'(DBG));
      cyc();
      bus.dbg_valid = 0;
      #1;
      chk("dbg_ready_drop", 32'(bus.dbg_ready), 0);
      cyc();
      cyc();
      chk("sb_drained", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
